frame_stats_accum: RTL
======================

Name: frame_stats_accum

Overview:
Per-port frame statistics accumulator. Consumes per-frame length/status events arriving over a multi-stage register slice from the MAC-side frame detector. Maintains free-running good/bad frame and byte counters. Provides an atomic snapshot, with optional clear, for the AXI register interface.

Parameters:
C_CNT_WIDTH, 64, width of every counter and snapshot output
C_LEN_WIDTH, 16, width of per-frame byte length input

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
enable  in  1  1 = accept events; 0 = events dropped at input stage
frame_valid  in  1  one-cycle pulse per completed frame
frame_bytes  in  C_LEN_WIDTH  frame length in bytes, valid with frame_valid
frame_good  in  1  1 = FCS ok, 0 = bad frame; valid with frame_valid
snap_req  in  1  one-cycle pulse: capture counters into snapshot registers
clear_req  in  1  one-cycle pulse: zero live counters
snap_good_frames  out  C_CNT_WIDTH  snapshot of good frame count
snap_bad_frames  out  C_CNT_WIDTH  snapshot of bad frame count
snap_good_bytes  out  C_CNT_WIDTH  snapshot of good byte count
snap_bad_bytes  out  C_CNT_WIDTH  snapshot of bad byte count
snap_valid  out  1  one-cycle pulse when snapshot outputs updated
live_good_frames  out  C_CNT_WIDTH  live good frame counter (debug/ILA)

Behaviour:
- Reset (rst=1 at an edge): all counters, snapshots, live_good_frames = 0; snap_valid = 0; input stage valid = 0. In-flight events are discarded.
- Stage 1, input register: ev_valid <= frame_valid & enable; length and good are captured.
- Stage 2, accumulate: on ev_valid, either good_frames+1 and good_bytes+len, or bad_frames+1 and bad_bytes+len.
- Latency: frame_valid at edge N appears in the live counters after edge N+1.
- Length is zero-extended to C_CNT_WIDTH. frame_bytes=0 still counts a frame and adds 0 bytes.
- All counters wrap modulo 2^C_CNT_WIDTH; there is no saturation and no overflow flag.
- Back-to-back events (frame_valid every cycle) are fully supported; each event is counted exactly once.
- Snapshot: at an edge with snap_req=1, snapshot registers load the current counter register values (pre-update). The snapshot includes events with frame_valid at edges up to k-2 and excludes the event being accumulated at edge k.
- snap_valid is high for exactly the cycle after edge k, coincident with the new snapshot values.
- Snapshot outputs hold their value until the next snap_req or rst.
- Clear: at an edge with clear_req=1, each counter loads only the contribution of the event accumulated at that edge (0 if none). Events are never lost across a clear; they are attributed to the new epoch.
- snap_req and clear_req at the same edge form an atomic read-and-clear: the snapshot receives pre-clear totals, and the counters restart from the in-flight contribution.
- snap_req on consecutive cycles: each one produces a snapshot and a snap_valid pulse.
- enable deasserting mid-stream: the event already in stage 1 is still accumulated; only new inputs are dropped.

Decomposition:
- Package frame_stats_pkg:
  - typedef stats_cnt_t struct {good_frames, bad_frames, good_bytes, bad_bytes}, each C_CNT_WIDTH wide.
  - localparam default widths.
- Sub-module stats_counter, instantiated 4x. Inputs: inc_en, delta, clear. Register rule: cnt <= (clear ? 0 : cnt) + (inc_en ? delta : 0).
- Top level holds the input stage, snapshot registers and snap_valid.

Test Plan:
- Reset, then 3 good frames of 64, 1500, 0 bytes, then snap_req -> snap_good_frames=3, snap_good_bytes=1564, bad counters 0, one snap_valid pulse.
- 10 back-to-back frame_valid cycles, alternating good/bad, all 100 bytes -> good_frames=5, bad_frames=5, good_bytes=500, bad_bytes=500.
- Good 200-byte frame at edge N, snap_req+clear_req at edge N+1 -> snapshot excludes it (0 frames); next snap_req shows 1 frame / 200 bytes.
- Counter preloaded via forced state to 2^64-10, then add a 20-byte good frame -> good_bytes=10 (wrap).
- enable=0 while sending 5 frames -> no counter change; enable drops the cycle after a frame pulse -> that frame is still counted.
- rst asserted one cycle after frame_valid -> all outputs 0, that frame is not counted, and snap_valid stays low.

Source files
------------

// File: rtl/frame_stats_pkg.sv
// frame_stats_pkg: shared types and defaults for the per-port frame
// statistics accumulator.
//   - default counter / length widths
//   - counter lane indices, so the top and the bench agree on ordering
//   - stats_cnt_t: the four statistics as one record
package frame_stats_pkg;

    localparam int C_CNT_WIDTH_DEF = 64;
    localparam int C_LEN_WIDTH_DEF = 16;

    // Lane order of the four counters inside the top-level packed arrays.
    localparam int IDX_GOOD_FRAMES = 0;
    localparam int IDX_BAD_FRAMES  = 1;
    localparam int IDX_GOOD_BYTES  = 2;
    localparam int IDX_BAD_BYTES   = 3;
    localparam int NUM_CNT         = 4;

    typedef struct packed {
        logic [C_CNT_WIDTH_DEF-1:0] good_frames;
        logic [C_CNT_WIDTH_DEF-1:0] bad_frames;
        logic [C_CNT_WIDTH_DEF-1:0] good_bytes;
        logic [C_CNT_WIDTH_DEF-1:0] bad_bytes;
    } stats_cnt_t;

endpackage

// File: rtl/frame_stats_accum_counter.sv
// stats_counter: one wrapping accumulator lane.
//   clk, rst : clock, synchronous active-high reset
//   inc_en   : add delta this cycle
//   delta    : amount to add
//   clear    : restart from zero; an increment at the same edge still lands
//   cnt      : current count, wraps modulo 2^W
module stats_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_en,
    input  logic [W-1:0] delta,
    input  logic         clear,
    output logic [W-1:0] cnt
);

    // Clear zeroes the base, not the sum, so an event accumulated at the
    // clearing edge is attributed to the new epoch instead of being lost.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= (clear ? '0 : cnt) + (inc_en ? delta : '0);
    end

endmodule

// File: rtl/frame_stats_accum.sv
// frame_stats_accum: per-port good/bad frame and byte statistics.
//   clk, rst            : clock, synchronous active-high reset
//   enable              : gate for new frame events at the input stage
//   frame_valid/bytes/good : one-cycle frame completion event
//   snap_req            : capture the counters into the snapshot registers
//   clear_req           : restart the live counters
//   snap_*              : held snapshot values
//   snap_valid          : one-cycle pulse coincident with a new snapshot
//   live_good_frames    : live good-frame counter
module frame_stats_accum
    import frame_stats_pkg::*;
#(
    parameter int C_CNT_WIDTH = C_CNT_WIDTH_DEF,
    parameter int C_LEN_WIDTH = C_LEN_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   frame_valid,
    input  logic [C_LEN_WIDTH-1:0] frame_bytes,
    input  logic                   frame_good,
    input  logic                   snap_req,
    input  logic                   clear_req,
    output logic [C_CNT_WIDTH-1:0] snap_good_frames,
    output logic [C_CNT_WIDTH-1:0] snap_bad_frames,
    output logic [C_CNT_WIDTH-1:0] snap_good_bytes,
    output logic [C_CNT_WIDTH-1:0] snap_bad_bytes,
    output logic                   snap_valid,
    output logic [C_CNT_WIDTH-1:0] live_good_frames
);

    // Input stage: only the valid bit needs reset; payload is don't-care
    // whenever ev_valid is low.
    logic                   ev_valid;
    logic [C_LEN_WIDTH-1:0] ev_len;
    logic                   ev_good;

    always_ff @(posedge clk) begin
        if (rst)
            ev_valid <= 1'b0;
        else
            ev_valid <= frame_valid & enable;
        ev_len  <= frame_bytes;
        ev_good <= frame_good;
    end

    logic [NUM_CNT-1:0]                  inc;
    logic [NUM_CNT-1:0][C_CNT_WIDTH-1:0] delta;
    logic [NUM_CNT-1:0][C_CNT_WIDTH-1:0] cnt_q;
    logic [NUM_CNT-1:0][C_CNT_WIDTH-1:0] snap_q;
    logic [C_CNT_WIDTH-1:0]              len_ext;

    assign len_ext = C_CNT_WIDTH'(ev_len);

    always_comb begin
        inc   = '0;
        delta = '0;
        inc[IDX_GOOD_FRAMES]   = ev_valid &  ev_good;
        inc[IDX_BAD_FRAMES]    = ev_valid & ~ev_good;
        inc[IDX_GOOD_BYTES]    = ev_valid &  ev_good;
        inc[IDX_BAD_BYTES]     = ev_valid & ~ev_good;
        delta[IDX_GOOD_FRAMES] = C_CNT_WIDTH'(1);
        delta[IDX_BAD_FRAMES]  = C_CNT_WIDTH'(1);
        delta[IDX_GOOD_BYTES]  = len_ext;
        delta[IDX_BAD_BYTES]   = len_ext;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CNT; g++) begin : g_cnt
            stats_counter #(.W(C_CNT_WIDTH)) u_cnt (
                .clk    (clk),
                .rst    (rst),
                .inc_en (inc[g]),
                .delta  (delta[g]),
                .clear  (clear_req),
                .cnt    (cnt_q[g])
            );
        end
    endgenerate

    // Snapshot takes the registered (pre-update) counters, so a same-edge
    // clear_req gives an atomic read-and-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q     <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= snap_req;
            if (snap_req)
                snap_q <= cnt_q;
        end
    end

    assign snap_good_frames = snap_q[IDX_GOOD_FRAMES];
    assign snap_bad_frames  = snap_q[IDX_BAD_FRAMES];
    assign snap_good_bytes  = snap_q[IDX_GOOD_BYTES];
    assign snap_bad_bytes   = snap_q[IDX_BAD_BYTES];
    assign live_good_frames = cnt_q[IDX_GOOD_FRAMES];

endmodule
